// File: rtl/mux_n_skid_pkg.sv
// mux_pkg: shared handshake state encoding and select-width helper for the N-way select stage.
package mux_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mux_n_skid_if.sv
// mux_n_skid_if: upstream offer, downstream handshake and status of the select stage.
interface mux_n_skid_if #(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 4,
    parameter int ERR_CNT_W = 8
);
    import mux_pkg::*;
    localparam int SEL_W = sel_width(NUM_IN);
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        select;
    logic [NUM_IN*WIDTH-1:0] data_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_sel_err;
    logic [ERR_CNT_W-1:0]    err_count;

    modport master (
        output flush, in_valid, select, data_in, out_ready,
        input  in_ready, out_valid, out_data, out_sel_err, err_count
    );
    modport slave (
        input  flush, in_valid, select, data_in, out_ready,
        output in_ready, out_valid, out_data, out_sel_err, err_count
    );
endinterface

// File: rtl/mux_n_skid_comb.sv
// mux_n_comb: combinational N-way select with out-of-range flag and default value.
module mux_n_comb import mux_pkg::*; #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 4,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    localparam int              SEL_W       = sel_width(NUM_IN)
) (
    input  logic [SEL_W-1:0]        select,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]        sel_val,
    output logic                    err
);
    // every select code is in range when NUM_IN fills the select space
    localparam bit IS_POW2 = (NUM_IN & (NUM_IN - 1)) == 0;

    always_comb begin
        sel_val = DEFAULT_VAL;
        for (int k = 0; k < NUM_IN; k++)
            if (int'(select) == k) sel_val = data_in[k*WIDTH +: WIDTH];
    end

    assign err = !IS_POW2 && (int'(select) >= NUM_IN);
endmodule

// File: rtl/mux_n_skid.sv
// mux_n_skid: registered N-way select stage with valid/ready handshake and a one-deep skid buffer.
module mux_n_skid import mux_pkg::*; #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 4,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    parameter int               ERR_CNT_W   = 8
) (
    input logic         clk,
    input logic         rst_n,
    mux_n_skid_if.slave bus
);
    state_t               r_state, w_next;
    logic [WIDTH-1:0]     r_main, r_skid, w_sel_val;
    logic                 r_main_err, r_skid_err, w_err;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic                 w_in_ready, w_out_valid, w_accept, w_emit;
    logic                 w_load_main, w_load_skid, w_skid_to_main;

    mux_n_comb #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .DEFAULT_VAL(DEFAULT_VAL)) u_comb (
        .select  (bus.select),
        .data_in (bus.data_in),
        .sel_val (w_sel_val),
        .err     (w_err)
    );

    // ready comes from state only, so out_ready never reaches in_ready combinationally
    assign w_in_ready      = (r_state != FULL);
    assign w_out_valid     = (r_state != EMPTY);
    assign w_accept        = bus.in_valid && w_in_ready;
    assign w_emit          = w_out_valid && bus.out_ready;
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = r_main;
    assign bus.out_sel_err = r_main_err;
    assign bus.err_count   = r_err_count;

    always_comb begin
        w_next         = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            EMPTY: if (w_accept) begin
                w_next      = ONE;
                w_load_main = 1'b1;
            end
            ONE: if (w_accept && !w_emit) begin
                w_next      = FULL;
                w_load_skid = 1'b1;
            end else if (w_accept) begin
                w_load_main = 1'b1;
            end else if (w_emit) begin
                w_next = EMPTY;
            end
            FULL: if (w_emit) begin
                w_next         = ONE;
                w_skid_to_main = 1'b1;
            end
            default: w_next = EMPTY;
        endcase
        if (bus.flush) begin
            w_next         = EMPTY;
            w_load_main    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_main = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_main_err  <= 1'b0;
            r_skid      <= '0;
            r_skid_err  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_main) begin
                r_main     <= w_sel_val;
                r_main_err <= w_err;
            end else if (w_skid_to_main) begin
                r_main     <= r_skid;
                r_main_err <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid     <= w_sel_val;
                r_skid_err <= w_err;
            end
            // flushed accepts still count
            if (w_accept && w_err && !(&r_err_count)) r_err_count <= r_err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_n_skid.sv
// tb_mux_n_skid: NUM_IN=3 and NUM_IN=4 stages driven in lockstep, checked against a queue model.
module tb_mux_n_skid;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, out_ready, flush;
    logic [1:0]   sel;
    logic [127:0] din;
    logic         chk_en = 1'b0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    mux_n_skid_if #(.WIDTH(32), .NUM_IN(3)) b3 ();
    mux_n_skid_if #(.WIDTH(32), .NUM_IN(4)) b4 ();

    mux_n_skid #(.WIDTH(32), .NUM_IN(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    mux_n_skid #(.WIDTH(32), .NUM_IN(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    assign b3.in_valid  = in_valid;
    assign b3.out_ready = out_ready;
    assign b3.flush     = flush;
    assign b3.select    = sel;
    assign b3.data_in   = din[95:0];
    assign b4.in_valid  = in_valid;
    assign b4.out_ready = out_ready;
    assign b4.flush     = flush;
    assign b4.select    = sel;
    assign b4.data_in   = din;

    logic        ir[2], ov[2], se[2];
    logic [31:0] od[2];
    logic [7:0]  ecd[2];
    assign ir[0] = b3.in_ready;    assign ir[1] = b4.in_ready;
    assign ov[0] = b3.out_valid;   assign ov[1] = b4.out_valid;
    assign se[0] = b3.out_sel_err; assign se[1] = b4.out_sel_err;
    assign od[0] = b3.out_data;    assign od[1] = b4.out_data;
    assign ecd[0] = b3.err_count;  assign ecd[1] = b4.err_count;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: ordered queue of {err,data} holding at most two entries, plus saturating counter
    logic [32:0] q[2][$];
    int          ec[2];
    int          nin[2] = '{3, 4};
    logic        m_rej = 1'b0;
    logic [31:0] cap[$];

    always @(posedge clk) begin
        bit acc;
        m_rej = rst_n && in_valid && q[0].size() == 2;
        if (b3.out_valid && b3.out_ready) cap.push_back(b3.out_data);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                q[d].delete();
                ec[d] = 0;
            end else begin
                acc = in_valid && q[d].size() < 2;
                if (q[d].size() > 0 && out_ready) void'(q[d].pop_front());
                if (acc && int'(sel) >= nin[d] && ec[d] < 255) ec[d]++;
                if (flush) q[d].delete();
                else if (acc) q[d].push_back(int'(sel) < nin[d] ? {1'b0, din[sel*32 +: 32]} : 33'h1_0000_0000);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("in_ready[%0d]", d), ir[d], q[d].size() < 2);
                check($sformatf("out_valid[%0d]", d), ov[d], q[d].size() > 0);
                check($sformatf("err_count[%0d]", d), ecd[d], ec[d]);
                if (q[d].size() > 0) begin
                    check($sformatf("out_data[%0d]", d), od[d], q[d][0][31:0]);
                    check($sformatf("out_sel_err[%0d]", d), se[d], q[d][0][32]);
                end
            end
        end
    end

    logic [31:0] e3[3] = '{32'h11, 32'h22, 32'h33};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; sel = 2'd0;
        din = {32'h44, 32'h33, 32'h22, 32'h11};
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        check("rst out_valid", b3.out_valid, 1'b0);
        check("rst out_data", b3.out_data, 32'h0);
        check("rst err_count", b3.err_count, 8'd0);
        check("rst in_ready", b3.in_ready, 1'b1);
        // basic select, 1-cycle latency
        rst_n = 1'b1; sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("sel2 valid", b4.out_valid, 1'b1);
        check("sel2 data", b4.out_data, 32'h33);
        check("sel2 err", b4.out_sel_err, 1'b0);
        // out-of-range select on 3 inputs, in range on 4
        sel = 2'd3;
        @(negedge clk);
        check("oor data", b3.out_data, 32'h0);
        check("oor err", b3.out_sel_err, 1'b1);
        check("oor count", b3.err_count, 8'd1);
        check("pow2 data", b4.out_data, 32'h44);
        check("pow2 err", b4.out_sel_err, 1'b0);
        repeat (260) @(negedge clk);
        check("sat count", b3.err_count, 8'd255);
        in_valid = 1'b0;
        @(negedge clk);
        // backpressure: skid fills, then drains in order
        cap.delete();
        in_valid = 1'b1; sel = 2'd0; out_ready = 1'b0;
        @(negedge clk); sel = 2'd1;
        @(negedge clk);
        check("full in_ready", b3.in_ready, 1'b0);
        sel = 2'd2; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("drain count", cap.size(), 3);
        for (int i = 0; i < cap.size() && i < 3; i++) check($sformatf("drain[%0d]", i), cap[i], e3[i]);
        // flush in FULL
        in_valid = 1'b1; sel = 2'd0; out_ready = 1'b0;
        @(negedge clk); sel = 2'd1;
        @(negedge clk); in_valid = 1'b0;
        check("pre-flush full", b3.in_ready, 1'b0);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush valid", b3.out_valid, 1'b0);
        check("flush ready", b3.in_ready, 1'b1);
        check("flush count", b3.err_count, 8'd255);
        // reset in FULL
        in_valid = 1'b1; sel = 2'd0;
        @(negedge clk); sel = 2'd1;
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("mid-rst valid", b3.out_valid, 1'b0);
        check("mid-rst count", b3.err_count, 8'd0);
        check("mid-rst data", b3.out_data, 32'h0);
        in_valid = 1'b1; sel = 2'd1; out_ready = 1'b1;
        @(negedge clk);
        check("post-rst data", b3.out_data, 32'h22);
        // flushed out-of-range accept still counts
        flush = 1'b1; sel = 2'd3;
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        check("flush-acc valid", b3.out_valid, 1'b0);
        check("flush-acc count", b3.err_count, 8'd1);
        check("flush-acc count4", b4.err_count, 8'd0);
        // random traffic; upstream holds a rejected offer
        repeat (10000) begin
            @(negedge clk);
            if (!m_rej) begin
                in_valid = 1'($urandom_range(0, 1));
                sel = 2'($urandom_range(0, 3));
                din = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            out_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk); in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
